// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parametrised synchronous FIFO with status and sticky error flags
//
// Circular buffer with explicit wrap pointers and a registered occupancy counter.
// Ports:
//   clk          clock, all state on rising edge
//   rst          asynchronous active-low reset
//   limpar       synchronous flush (pointers, occupancy, flags, valido_sai)
//   escrever     write request, data_ent carries the word
//   ler          read request; data_sai/valido_sai valid one cycle later
//   data_sai     registered read data, holds last value when no read
//   valido_sai   data_sai holds a newly read word this cycle
//   fila_cheia   ocupacao == DEPTH
//   fila_vazia   ocupacao == 0
//   quase_cheia  ocupacao >= QUASE_TH
//   ocupacao     number of stored entries
//   estouro      sticky: write rejected while full
//   subfluxo     sticky: read rejected while empty
module fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int QUASE_TH = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       limpar,
    input  logic                       escrever,
    input  logic [DATA_W-1:0]          data_ent,
    input  logic                       ler,
    output logic [DATA_W-1:0]          data_sai,
    output logic                       valido_sai,
    output logic                       fila_cheia,
    output logic                       fila_vazia,
    output logic                       quase_cheia,
    output logic [$clog2(DEPTH+1)-1:0] ocupacao,
    output logic                       estouro,
    output logic                       subfluxo
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_TH   = CNT_W'(QUASE_TH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic full, empty;
    logic rd_acc, wr_acc;
    logic mem_we;

    // Status is decoded from the registered count only, so no input reaches an output
    // combinationally.
    assign full  = (cnt_q == CNT_FULL);
    assign empty = (cnt_q == '0);

    // A write into a full FIFO is still accepted when a read frees the slot on the same edge;
    // the read sees the old word because the array update is non-blocking.
    assign rd_acc = ler && !empty;
    assign wr_acc = escrever && (!full || rd_acc);

    // Flush and reset both suppress the array write so nothing leaks into the next fill.
    assign mem_we = wr_acc && !limpar && rst;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        if (limpar) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            // Wrap by explicit compare so non power-of-two depths work.
            if (wr_acc) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
                data_d   = mem[rd_ptr_q];
                valid_d  = 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
            if (escrever && !wr_acc) begin
                ovf_d = 1'b1;
            end
            if (ler && !rd_acc) begin
                udf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is not reset; the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= data_ent;
        end
    end

    assign data_sai    = data_q;
    assign valido_sai  = valid_q;
    assign fila_cheia  = full;
    assign fila_vazia  = empty;
    assign quase_cheia = (cnt_q >= CNT_TH);
    assign ocupacao    = cnt_q;
    assign estouro     = ovf_q;
    assign subfluxo    = udf_q;

endmodule

// File: tb/tb_fifo_param.sv
// tb/tb_fifo_param.sv - directed self-checking bench for fifo_param (DEPTH 8 and DEPTH 5)
module tb_fifo_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;

    logic       limpar, escrever, ler;
    logic [7:0] data_ent, data_sai;
    logic       valido_sai, fila_cheia, fila_vazia, quase_cheia, estouro, subfluxo;
    logic [3:0] ocupacao;

    logic       limpar5, escrever5, ler5;
    logic [7:0] data_ent5, data_sai5;
    logic       valido_sai5, fila_cheia5, fila_vazia5, quase_cheia5, estouro5, subfluxo5;
    logic [2:0] ocupacao5;

    int n_checks = 0;
    int n_errors = 0;

    fifo_param #(.DATA_W(8), .DEPTH(8), .QUASE_TH(6)) dut8 (
        .clk(clk), .rst(rst), .limpar(limpar), .escrever(escrever), .data_ent(data_ent),
        .ler(ler), .data_sai(data_sai), .valido_sai(valido_sai), .fila_cheia(fila_cheia),
        .fila_vazia(fila_vazia), .quase_cheia(quase_cheia), .ocupacao(ocupacao),
        .estouro(estouro), .subfluxo(subfluxo)
    );

    fifo_param #(.DATA_W(8), .DEPTH(5), .QUASE_TH(4)) dut5 (
        .clk(clk), .rst(rst), .limpar(limpar5), .escrever(escrever5), .data_ent(data_ent5),
        .ler(ler5), .data_sai(data_sai5), .valido_sai(valido_sai5), .fila_cheia(fila_cheia5),
        .fila_vazia(fila_vazia5), .quase_cheia(quase_cheia5), .ocupacao(ocupacao5),
        .estouro(estouro5), .subfluxo(subfluxo5)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr8(input logic [7:0] d);
        escrever = 1'b1;
        data_ent = d;
        tick();
        escrever = 1'b0;
    endtask

    task automatic flush8();
        limpar = 1'b1;
        tick();
        limpar = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        n_checks++;
        if (ocupacao !== 4'd0 || fila_vazia !== 1'b1 || fila_cheia !== 1'b0 || quase_cheia !== 1'b0 ||
            estouro !== 1'b0 || subfluxo !== 1'b0 || valido_sai !== 1'b0 || data_sai !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_state: ocup=%0d vazia=%b cheia=%b quase=%b est=%b sub=%b val=%b data=%h, need 0 1 0 0 0 0 0 00",
                     ocupacao, fila_vazia, fila_cheia, quase_cheia, estouro, subfluxo, valido_sai, data_sai);
        end
        rst = 1'b1;
        tick();
        wr8(8'h31); wr8(8'h32); wr8(8'h33);
        ler = 1'b1;
        tick();
        ler = 1'b0;
        n_checks++;
        if (valido_sai !== 1'b1 || data_sai !== 8'h31 || ocupacao !== 4'd2) begin
            n_errors++;
            $display("FAIL pre_reset_read: val=%b data=%h ocup=%0d, need 1 31 2", valido_sai, data_sai, ocupacao);
        end
        // Asynchronous reset in the middle of a cycle takes effect without a clock edge.
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (ocupacao !== 4'd0 || valido_sai !== 1'b0 || data_sai !== 8'h00) begin
            n_errors++;
            $display("FAIL async_reset: ocup=%0d val=%b data=%h, need 0 0 00", ocupacao, valido_sai, data_sai);
        end
        tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if (fila_vazia !== 1'b1 || ocupacao !== 4'd0 || estouro !== 1'b0 || subfluxo !== 1'b0) begin
            n_errors++;
            $display("FAIL post_reset: vazia=%b ocup=%0d est=%b sub=%b, need 1 0 0 0", fila_vazia, ocupacao, estouro, subfluxo);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 8; i++) begin
            wr8(8'(i));
            n_checks++;
            if (ocupacao !== 4'(i) || quase_cheia !== (i >= 6) || fila_cheia !== (i == 8) || fila_vazia !== 1'b0) begin
                n_errors++;
                $display("FAIL fill_%0d: ocup=%0d quase=%b cheia=%b vazia=%b, need %0d %b %b 0",
                         i, ocupacao, quase_cheia, fila_cheia, fila_vazia, i, (i >= 6), (i == 8));
            end
        end
        for (int i = 1; i <= 8; i++) begin
            ler = 1'b1;
            tick();
            ler = 1'b0;
            n_checks++;
            if (valido_sai !== 1'b1 || data_sai !== 8'(i) || ocupacao !== 4'(8 - i)) begin
                n_errors++;
                $display("FAIL drain_%0d: val=%b data=%h ocup=%0d, need 1 %h %0d",
                         i, valido_sai, data_sai, ocupacao, 8'(i), 8 - i);
            end
        end
        tick();
        n_checks++;
        if (valido_sai !== 1'b0 || data_sai !== 8'h08 || fila_vazia !== 1'b1 || subfluxo !== 1'b0) begin
            n_errors++;
            $display("FAIL drain_idle: val=%b data=%h vazia=%b sub=%b, need 0 08 1 0", valido_sai, data_sai, fila_vazia, subfluxo);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 8; i++) wr8(8'h40 + 8'(i));
        wr8(8'hAA);
        n_checks++;
        if (estouro !== 1'b1 || ocupacao !== 4'd8 || fila_cheia !== 1'b1) begin
            n_errors++;
            $display("FAIL overflow_flag: est=%b ocup=%0d cheia=%b, need 1 8 1", estouro, ocupacao, fila_cheia);
        end
        for (int i = 1; i <= 8; i++) begin
            ler = 1'b1;
            tick();
            ler = 1'b0;
            n_checks++;
            if (data_sai !== 8'h40 + 8'(i) || valido_sai !== 1'b1) begin
                n_errors++;
                $display("FAIL overflow_drain_%0d: data=%h val=%b, need %h 1", i, data_sai, valido_sai, 8'h40 + 8'(i));
            end
        end
        n_checks++;
        if (fila_vazia !== 1'b1 || estouro !== 1'b1) begin
            n_errors++;
            $display("FAIL overflow_sticky: vazia=%b est=%b, need 1 1", fila_vazia, estouro);
        end
        flush8();
    endtask

    task automatic test_underflow_simul();
        escrever = 1'b1;
        data_ent = 8'h5C;
        ler = 1'b1;
        tick();
        escrever = 1'b0;
        ler = 1'b0;
        n_checks++;
        if (subfluxo !== 1'b1 || ocupacao !== 4'd1 || valido_sai !== 1'b0 || estouro !== 1'b0) begin
            n_errors++;
            $display("FAIL underflow_simul: sub=%b ocup=%0d val=%b est=%b, need 1 1 0 0", subfluxo, ocupacao, valido_sai, estouro);
        end
        ler = 1'b1;
        tick();
        ler = 1'b0;
        n_checks++;
        if (data_sai !== 8'h5C || valido_sai !== 1'b1 || ocupacao !== 4'd0 || subfluxo !== 1'b1) begin
            n_errors++;
            $display("FAIL underflow_read: data=%h val=%b ocup=%0d sub=%b, need 5c 1 0 1", data_sai, valido_sai, ocupacao, subfluxo);
        end
        flush8();
    endtask

    task automatic test_full_concurrent();
        // Offset the pointers first so the concurrent access straddles the wrap point.
        wr8(8'hE0); wr8(8'hE1); wr8(8'hE2);
        ler = 1'b1; tick(); tick(); tick(); ler = 1'b0;
        for (int i = 0; i < 8; i++) wr8(8'h11 + 8'(i));
        escrever = 1'b1;
        data_ent = 8'h99;
        ler = 1'b1;
        tick();
        escrever = 1'b0;
        ler = 1'b0;
        n_checks++;
        if (ocupacao !== 4'd8 || data_sai !== 8'h11 || valido_sai !== 1'b1 || estouro !== 1'b0) begin
            n_errors++;
            $display("FAIL full_concurrent8: ocup=%0d data=%h val=%b est=%b, need 8 11 1 0", ocupacao, data_sai, valido_sai, estouro);
        end
        for (int i = 1; i <= 8; i++) begin
            logic [7:0] exp;
            exp = (i == 8) ? 8'h99 : 8'h11 + 8'(i);
            ler = 1'b1;
            tick();
            ler = 1'b0;
            n_checks++;
            if (data_sai !== exp || valido_sai !== 1'b1) begin
                n_errors++;
                $display("FAIL full_concurrent8_read_%0d: data=%h val=%b, need %h 1", i, data_sai, valido_sai, exp);
            end
        end

        for (int i = 0; i < 5; i++) begin
            escrever5 = 1'b1;
            data_ent5 = 8'h21 + 8'(i);
            tick();
        end
        escrever5 = 1'b0;
        n_checks++;
        if (fila_cheia5 !== 1'b1 || ocupacao5 !== 3'd5 || quase_cheia5 !== 1'b1) begin
            n_errors++;
            $display("FAIL fill5: cheia=%b ocup=%0d quase=%b, need 1 5 1", fila_cheia5, ocupacao5, quase_cheia5);
        end
        escrever5 = 1'b1;
        data_ent5 = 8'h99;
        ler5 = 1'b1;
        tick();
        escrever5 = 1'b0;
        n_checks++;
        if (ocupacao5 !== 3'd5 || data_sai5 !== 8'h21 || valido_sai5 !== 1'b1) begin
            n_errors++;
            $display("FAIL full_concurrent5: ocup=%0d data=%h val=%b, need 5 21 1", ocupacao5, data_sai5, valido_sai5);
        end
        for (int i = 1; i <= 5; i++) begin
            logic [7:0] exp;
            exp = (i == 5) ? 8'h99 : 8'h21 + 8'(i);
            tick();
            n_checks++;
            if (data_sai5 !== exp || valido_sai5 !== 1'b1) begin
                n_errors++;
                $display("FAIL full_concurrent5_read_%0d: data=%h val=%b, need %h 1", i, data_sai5, valido_sai5, exp);
            end
        end
        tick();
        ler5 = 1'b0;
        n_checks++;
        if (fila_vazia5 !== 1'b1 || subfluxo5 !== 1'b1 || valido_sai5 !== 1'b0 || data_sai5 !== 8'h99) begin
            n_errors++;
            $display("FAIL empty5: vazia=%b sub=%b val=%b data=%h, need 1 1 0 99", fila_vazia5, subfluxo5, valido_sai5, data_sai5);
        end
    endtask

    task automatic test_flush();
        for (int i = 1; i <= 8; i++) wr8(8'h60 + 8'(i));
        wr8(8'hBB);
        ler = 1'b1; tick(); tick(); tick(); tick(); ler = 1'b0;
        n_checks++;
        if (ocupacao !== 4'd4 || estouro !== 1'b1 || data_sai !== 8'h64) begin
            n_errors++;
            $display("FAIL flush_setup: ocup=%0d est=%b data=%h, need 4 1 64", ocupacao, estouro, data_sai);
        end
        limpar = 1'b1;
        escrever = 1'b1;
        data_ent = 8'h77;
        tick();
        limpar = 1'b0;
        escrever = 1'b0;
        n_checks++;
        if (ocupacao !== 4'd0 || estouro !== 1'b0 || fila_vazia !== 1'b1 || valido_sai !== 1'b0 || data_sai !== 8'h64) begin
            n_errors++;
            $display("FAIL flush: ocup=%0d est=%b vazia=%b val=%b data=%h, need 0 0 1 0 64",
                     ocupacao, estouro, fila_vazia, valido_sai, data_sai);
        end
        ler = 1'b1;
        tick();
        ler = 1'b0;
        n_checks++;
        if (subfluxo !== 1'b1 || valido_sai !== 1'b0 || data_sai !== 8'h64) begin
            n_errors++;
            $display("FAIL flush_write_ignored: sub=%b val=%b data=%h, need 1 0 64", subfluxo, valido_sai, data_sai);
        end
    endtask

    initial begin
        rst = 1'b0;
        limpar = 1'b0; escrever = 1'b0; ler = 1'b0; data_ent = '0;
        limpar5 = 1'b0; escrever5 = 1'b0; ler5 = 1'b0; data_ent5 = '0;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow_simul();
        test_full_concurrent();
        test_flush();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
